accel_spi_sched: RTL
====================

ACCEL_SPI_SCHED -- requirements
Module: accel_spi_sched

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal values 2..255).
REQ-002 Parameter POLL_PERIOD, default 5000, clk cycles between poll-burst triggers (minimum 512).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 poll_en  input  1  enables periodic polling bursts.
REQ-006 cpu_req  input  1  level request for one SPI register write.
REQ-007 cpu_addr  input  8  register address for the write.
REQ-008 cpu_wdata  input  8  data for the write.
REQ-009 cpu_ack  output  1  one-cycle pulse when the write transaction completes.
REQ-010 y_data  output  16  last Y sample, {reg 0x11, reg 0x10}.
REQ-011 z_data  output  16  last Z sample, {reg 0x13, reg 0x12}.
REQ-012 data_valid  output  1  one-cycle pulse when y_data/z_data update.
REQ-013 cs  output  1  SPI chip select, active low.
REQ-014 sclk  output  1  SPI clock, mode 0 (idles low).
REQ-015 mosi  output  1  SPI serial out, MSB first.
REQ-016 miso  input  1  SPI serial in.

Function
REQ-017 Each SPI transaction is 24 bits, MSB first: command byte, address byte, data byte; read command 0x0B, write command 0x0A.
REQ-018 Transaction timing: cs falls with mosi = bit 23, then CLK_DIV cycles of setup; 24 × (CLK_DIV high + CLK_DIV low) sclk cycles; cs rises; cs stays low exactly 49·CLK_DIV cycles.
REQ-019 miso is sampled in the clk cycle sclk rises; mosi changes only in the cycle sclk falls.
REQ-020 Read data is the last 8 miso samples (bits 7..0).
REQ-021 cs stays high for at least 2·CLK_DIV cycles between transactions.
REQ-022 FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP. Transitions: IDLE→SETUP on grant; SETUP→SHIFT_HI after CLK_DIV; SHIFT_HI→SHIFT_LO after CLK_DIV; SHIFT_LO→SHIFT_HI (bits remain) or →GAP (24th bit done, cs rises); GAP→IDLE after 2·CLK_DIV.
REQ-023 The poll timer free-runs 0..POLL_PERIOD-1 and sets poll_pend on wrap when poll_en=1; a second wrap while pending does not queue.
REQ-024 A burst is sequential reads of 0x10, 0x11, 0x12, 0x13; poll_pend clears when the burst's first transaction is granted.
REQ-025 Arbitration occurs only in IDLE: cpu_req wins over the next burst read.
REQ-026 A CPU write may be inserted between reads of a burst; the burst then resumes at the next address.
REQ-027 cpu_addr/cpu_wdata are latched at grant; cpu_ack pulses in the cycle cs rises for that write.
REQ-028 The requester deasserts cpu_req the cycle after cpu_ack; a request still high then is a new request.
REQ-029 Burst bytes go to shadow registers; y_data/z_data update together and data_valid pulses in the cycle cs rises after the final burst read.
REQ-030 Clearing poll_en mid-burst finishes the burst; only future triggers are suppressed.

Reset
REQ-031 On reset: cs=1, sclk=0, mosi=0, cpu_ack=0, data_valid=0, y_data=0, z_data=0, poll timer=0, poll_pend=0, burst index=0, FSM=IDLE.
REQ-032 Reset mid-transaction aborts it: cs high and sclk low the cycle after reset is sampled, and no ack or valid is issued.

Configuration
REQ-033 Macro ACCEL_Z_POLL_EN: when defined, a burst reads 0x10..0x13.
REQ-034 When ACCEL_Z_POLL_EN is not defined, a burst reads only 0x10 and 0x11, data_valid follows the 0x11 read, and z_data is held at 0.

Structure
REQ-035 Package accel_spi_pkg holds the command constants (0x0B, 0x0A), register addresses 0x10..0x13, and the FSM state encoding.
REQ-036 A sub-module spi_xfer24 implements REQ-017..REQ-022 (start, 24-bit shift, done pulse, 8-bit rdata); accel_spi_sched owns the timer, arbitration and result registers.

Verification
REQ-037 Slave model returns 5, 10, 15, 20 for 0x10..0x13, poll_en=1 -> data_valid pulse, y_data=0x0A05, z_data=0x140F.
REQ-038 CLK_DIV=4, one transaction -> cs low exactly 196 cycles, 24 sclk rising edges, mosi bytes 0x0B,0x10,0x00.
REQ-039 cpu_req addr 0x2D, wdata 0x02 raised during a burst's 0x11 read -> next transaction is 0x0A,0x2D,0x02, then cpu_ack, then the 0x12 read, and a single data_valid.
REQ-040 Reset asserted on the 12th sclk edge -> cs=1 next cycle, y_data=0, no data_valid; the next burst completes normally.
REQ-041 poll_en=0 -> no cs activity for 3·POLL_PERIOD cycles; a cpu write still completes with cpu_ack.
REQ-042 Build without ACCEL_Z_POLL_EN -> 2 transactions per burst, z_data=0, y_data=0x0A05.

Source files
------------

// File: rtl/accel_spi_sched_pkg.sv
// accel_spi_pkg: shared constants for the accelerometer SPI poll scheduler.
//   - SPI command bytes (read 0x0B, write 0x0A)
//   - sample register addresses 0x10..0x13 (Y lo/hi, Z lo/hi)
//   - state encoding of the 24-bit transfer engine
//   - spi_frame(): packs command/address/data into one 24-bit frame
package accel_spi_pkg;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    localparam logic [7:0] REG_Y_LO = 8'h10;
    localparam logic [7:0] REG_Y_HI = 8'h11;
    localparam logic [7:0] REG_Z_LO = 8'h12;
    localparam logic [7:0] REG_Z_HI = 8'h13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_GAP
    } xfer_state_t;

    function automatic logic [23:0] spi_frame(input logic [7:0] cmd,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
        return {cmd, addr, data};
    endfunction

endpackage

// File: rtl/accel_spi_sched_if.sv
// accel_spi_sched_if: 4-wire SPI bus between the scheduler and the sensor.
//   cs   - chip select, active low
//   sclk - serial clock, mode 0 (idles low)
//   mosi - controller to sensor data, MSB first
//   miso - sensor to controller data
// Modports: master (controller side), slave (sensor side).
interface accel_spi_sched_if;
    logic cs;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output cs, output sclk, output mosi, input miso);
    modport slave  (input cs, input sclk, input mosi, output miso);
endinterface

// File: rtl/accel_spi_sched_spi_xfer24.sv
// spi_xfer24: one 24-bit mode-0 SPI transaction per start pulse.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   start      - launch a transaction with frame tx (only honoured when ready)
//   tx         - {command, address, data}, shifted MSB first
//   ready      - engine idle, start will be accepted this cycle
//   done       - strobe in the last cs-low cycle; the parent registers its
//                results on the same edge that raises cs
//   rdata      - last 8 miso samples of the transaction
//   spi        - SPI bus (master modport)
// cs is low for CLK_DIV setup + 24 full sclk periods = 49*CLK_DIV cycles,
// then held high for 2*CLK_DIV gap cycles before the next start.
module spi_xfer24
    import accel_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [23:0]        tx,
    output logic               ready,
    output logic               done,
    output logic [7:0]         rdata,
    accel_spi_sched_if.master  spi
);

    localparam logic [8:0] HALF_M1 = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_M1  = 9'(2 * CLK_DIV - 1);

    xfer_state_t state, state_n;
    logic [8:0]  cnt, cnt_n;
    logic [4:0]  bit_cnt, bit_n;
    logic [23:0] tx_sr, tx_n;
    logic [7:0]  rx_sr, rx_n;
    logic        cs_q, cs_n;
    logic        sclk_q, sclk_n;
    logic        mosi_q, mosi_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            cs_q    <= cs_n;
            sclk_q  <= sclk_n;
            mosi_q  <= mosi_n;
        end
    end

    // All pin changes are computed here and registered, so sclk rise and
    // the miso sample happen on the same clock edge, and mosi moves only on
    // the edge that drops sclk.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        tx_n    = tx_sr;
        rx_n    = rx_sr;
        cs_n    = cs_q;
        sclk_n  = sclk_q;
        mosi_n  = mosi_q;
        done    = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = ST_SETUP;
                    cs_n    = 1'b0;
                    mosi_n  = tx[23];
                    tx_n    = tx;
                    bit_n   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = ST_SHIFT_HI;
                    sclk_n  = 1'b1;
                    rx_n    = {rx_sr[6:0], spi.miso};
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = ST_SHIFT_LO;
                    sclk_n  = 1'b0;
                    bit_n   = bit_cnt + 5'd1;
                    tx_n    = {tx_sr[22:0], 1'b0};
                    mosi_n  = tx_sr[22];
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (bit_cnt == 5'd24) begin
                        state_n = ST_GAP;
                        cs_n    = 1'b1;
                        done    = 1'b1;
                    end else begin
                        state_n = ST_SHIFT_HI;
                        sclk_n  = 1'b1;
                        rx_n    = {rx_sr[6:0], spi.miso};
                    end
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_M1) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign ready    = (state == ST_IDLE);
    assign rdata    = rx_sr;
    assign spi.cs   = cs_q;
    assign spi.sclk = sclk_q;
    assign spi.mosi = mosi_q;

endmodule

// File: rtl/accel_spi_sched.sv
// accel_spi_sched: periodic accelerometer poller with CPU write insertion.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   poll_en              - enables periodic poll bursts
//   cpu_req              - level request for one register write
//   cpu_addr, cpu_wdata  - write address/data, latched at grant
//   cpu_ack              - pulse in the cycle cs rises for the write
//   y_data, z_data       - last samples {0x11,0x10} and {0x13,0x12}
//   data_valid           - pulse when y_data/z_data update
//   spi                  - SPI bus (master modport)
// Build option: ACCEL_Z_POLL_EN defined -> bursts read 0x10..0x13;
// undefined -> bursts read 0x10..0x11 and z_data stays 0.
module accel_spi_sched
    import accel_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned POLL_PERIOD = 5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               poll_en,
    input  logic               cpu_req,
    input  logic [7:0]         cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [15:0]        y_data,
    output logic [15:0]        z_data,
    output logic               data_valid,
    accel_spi_sched_if.master  spi
);

`ifdef ACCEL_Z_POLL_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    localparam int unsigned     TW   = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0]   TMAX = TW'(POLL_PERIOD - 1);

    logic [TW-1:0] timer;
    logic          timer_wrap;
    logic          poll_pend;
    logic          in_burst;
    logic [1:0]    burst_idx;
    logic          op_write;
    logic [7:0]    sh_y_lo;
`ifdef ACCEL_Z_POLL_EN
    logic [7:0]    sh_y_hi;
    logic [7:0]    sh_z_lo;
`endif

    logic          xfer_ready;
    logic          xfer_done;
    logic [7:0]    xfer_rdata;
    logic          start;
    logic          grant_write;
    logic [23:0]   tx_word;

    assign timer_wrap = (timer == TMAX);

    // Arbitration only while the engine is idle; a pending CPU write wins
    // over the next burst read, which simply resumes afterwards.
    assign grant_write = xfer_ready & cpu_req;
    assign start       = xfer_ready & (cpu_req | in_burst | poll_pend);
    assign tx_word     = grant_write ? spi_frame(CMD_WRITE, cpu_addr, cpu_wdata)
                                     : spi_frame(CMD_READ, REG_Y_LO + {6'd0, burst_idx}, 8'h00);

    spi_xfer24 #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .tx    (tx_word),
        .ready (xfer_ready),
        .done  (xfer_done),
        .rdata (xfer_rdata),
        .spi   (spi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timer      <= '0;
            poll_pend  <= 1'b0;
            in_burst   <= 1'b0;
            burst_idx  <= '0;
            op_write   <= 1'b0;
            cpu_ack    <= 1'b0;
            data_valid <= 1'b0;
            y_data     <= '0;
            sh_y_lo    <= '0;
`ifdef ACCEL_Z_POLL_EN
            z_data     <= '0;
            sh_y_hi    <= '0;
            sh_z_lo    <= '0;
`endif
        end else begin
            cpu_ack    <= 1'b0;
            data_valid <= 1'b0;
            timer      <= timer_wrap ? '0 : timer + 1'b1;

            if (start) begin
                op_write <= grant_write;
                if (!grant_write) begin
                    in_burst <= 1'b1;
                end
            end

            // Granting a burst's first read consumes the trigger; a new wrap
            // in the same cycle is a fresh trigger and takes precedence.
            if (start && !grant_write && !in_burst) begin
                poll_pend <= 1'b0;
            end
            if (timer_wrap && poll_en) begin
                poll_pend <= 1'b1;
            end

            if (xfer_done) begin
                if (op_write) begin
                    cpu_ack <= 1'b1;
                end else if (burst_idx == LAST_IDX) begin
`ifdef ACCEL_Z_POLL_EN
                    y_data <= {sh_y_hi, sh_y_lo};
                    z_data <= {xfer_rdata, sh_z_lo};
`else
                    y_data <= {xfer_rdata, sh_y_lo};
`endif
                    data_valid <= 1'b1;
                    burst_idx  <= '0;
                    in_burst   <= 1'b0;
                end else begin
                    case (burst_idx)
                        2'd0: sh_y_lo <= xfer_rdata;
`ifdef ACCEL_Z_POLL_EN
                        2'd1: sh_y_hi <= xfer_rdata;
                        2'd2: sh_z_lo <= xfer_rdata;
`endif
                        default: ;
                    endcase
                    burst_idx <= burst_idx + 2'd1;
                end
            end
        end
    end

`ifndef ACCEL_Z_POLL_EN
    assign z_data = '0;
`endif

endmodule
